// File: rtl/simon_pkg.sv
// Shared types and constants for the SIMON controller and datapath:
// controller state encoding and the z constant sequences indexed by round.
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LDKEY  = 3'd1,
    LDBLK  = 3'd2,
    ROUND  = 3'd3,
    OUTPUT = 3'd4,
    DROP   = 3'd5
  } state_t;

  localparam int unsigned Z_LEN = 62;
  localparam logic [2:0]  Z_NONE = 3'd7;

  // Leftmost character of each published sequence is round 0 (bit Z_LEN-1).
  localparam logic [Z_LEN-1:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [Z_LEN-1:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [Z_LEN-1:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [Z_LEN-1:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [Z_LEN-1:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  // Which z sequence a (word size, key words) geometry uses; Z_NONE if unsupported.
  function automatic logic [2:0] z_select(input int unsigned n, input int unsigned m);
    logic [2:0] sel;
    sel = Z_NONE;
    if      (n == 16 && m == 4) sel = 3'd0;
    else if (n == 24 && m == 3) sel = 3'd0;
    else if (n == 24 && m == 4) sel = 3'd1;
    else if (n == 32 && m == 3) sel = 3'd2;
    else if (n == 32 && m == 4) sel = 3'd3;
    else if (n == 48 && m == 2) sel = 3'd2;
    else if (n == 48 && m == 3) sel = 3'd3;
    else if (n == 64 && m == 2) sel = 3'd2;
    else if (n == 64 && m == 3) sel = 3'd3;
    else if (n == 64 && m == 4) sel = 3'd4;
    return sel;
  endfunction

  // z bit for a given round index; the sequences repeat with period Z_LEN.
  function automatic logic z_bit(input logic [2:0] sel, input int unsigned idx);
    int unsigned pos;
    logic [Z_LEN-1:0] seq;
    pos = (Z_LEN - 1) - (idx % Z_LEN);
    case (sel)
      3'd0:    seq = Z0;
      3'd1:    seq = Z1;
      3'd2:    seq = Z2;
      3'd3:    seq = Z3;
      default: seq = Z4;
    endcase
    return seq[pos];
  endfunction

endpackage

// File: rtl/simon_round_counter.sv
// Round index counter: clears to 0, steps on enable, saturates at T-1 and
// flags the last round combinationally.
module simon_round_counter #(
  parameter int unsigned T  = 32,
  parameter int unsigned Cb = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [Cb-1:0] count,
  output logic          last_c
);

  localparam logic [Cb-1:0] LAST = Cb'(T - 1);

  assign last_c = (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !last_c) begin
      count <= count + Cb'(1);
    end
  end

endmodule

// File: rtl/simon_round_ctrl.sv
// SIMON sequencing controller: arbitrates key/block loads, steps T rounds and
// holds the result until acknowledged. SIMON_ROUND_CTRL_ERRCHK_EN enables the
// DROP path that discards blocks arriving before any key.
module simon_round_ctrl
  import simon_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned M  = 4,
  parameter int unsigned T  = 32,
  parameter int unsigned Cb = 5
) (
  input  logic          clk,
  input  logic          R,
  input  logic          newKey,
  input  logic          newData,
  input  logic          outAck,
  output logic          loadKey,
  output logic          loadData,
  output logic          keyLoad,
  output logic          blockLoad,
  output logic          roundEn,
  output logic [Cb-1:0] roundCount,
  output logic          outValid,
  output logic          keyValid,
  output logic          err
);

  // Elaboration-time sanity checks on the configuration.
  if (T < 1 || T > (1 << Cb)) begin : g_bad_rounds
    $error("simon_round_ctrl: T must satisfy 1 <= T <= 2**Cb");
  end
  if (z_select(N, M) == Z_NONE) begin : g_bad_geometry
    $error("simon_round_ctrl: unsupported N/M geometry");
  end

  state_t state_q, state_d;
  logic   last_c;
  logic   load_key_d, load_data_d, key_load_d, block_load_d;
  logic   round_en_d, out_valid_d, key_valid_d, err_d;

  simon_round_counter #(.T(T), .Cb(Cb)) u_counter (
    .clk    (clk),
    .rst    (R),
    .clr    (state_d == LDBLK),
    .en     (state_q == ROUND),
    .count  (roundCount),
    .last_c (last_c)
  );

  // Next state, and Moore outputs decoded from the state being entered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (newKey)                   state_d = LDKEY;
        else if (newData && keyValid) state_d = LDBLK;
`ifdef SIMON_ROUND_CTRL_ERRCHK_EN
        else if (newData)             state_d = DROP;
`endif
      end
      LDKEY:   state_d = IDLE;
      LDBLK:   state_d = ROUND;
      ROUND:   if (last_c) state_d = OUTPUT;
      OUTPUT:  if (outAck) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    load_key_d   = (state_d == LDKEY);
    key_load_d   = (state_d == LDKEY);
    block_load_d = (state_d == LDBLK);
    round_en_d   = (state_d == ROUND);
    out_valid_d  = (state_d == OUTPUT);
    key_valid_d  = keyValid | (state_d == LDKEY);
`ifdef SIMON_ROUND_CTRL_ERRCHK_EN
    load_data_d  = (state_d == LDBLK) | (state_d == DROP);
    err_d        = (state_d == DROP);
`else
    load_data_d  = (state_d == LDBLK);
    err_d        = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q   <= IDLE;
      loadKey   <= 1'b0;
      loadData  <= 1'b0;
      keyLoad   <= 1'b0;
      blockLoad <= 1'b0;
      roundEn   <= 1'b0;
      outValid  <= 1'b0;
      keyValid  <= 1'b0;
    end else begin
      state_q   <= state_d;
      loadKey   <= load_key_d;
      loadData  <= load_data_d;
      keyLoad   <= key_load_d;
      blockLoad <= block_load_d;
      roundEn   <= round_en_d;
      outValid  <= out_valid_d;
      keyValid  <= key_valid_d;
    end
  end

`ifdef SIMON_ROUND_CTRL_ERRCHK_EN
  always_ff @(posedge clk or posedge R) begin
    if (R) err <= 1'b0;
    else   err <= err_d;
  end
`else
  assign err = 1'b0;
  logic unused_err_d;
  assign unused_err_d = err_d;
`endif

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Directed bench for simon_round_ctrl: expected handshake events are queued as
// stimulus is applied and matched in order as the controller produces them.
module tb_simon_round_ctrl;

  localparam int unsigned T_R  = 32;
  localparam int unsigned CB_R = 5;

  typedef enum int {EV_NONE, EV_KEY, EV_DATA, EV_DROP, EV_OUT} ev_t;

  logic            clk = 1'b0;
  logic            R = 1'b1;
  logic            newKey = 1'b0;
  logic            newData = 1'b0;
  logic            outAck = 1'b0;
  logic            loadKey, loadData, keyLoad, blockLoad, roundEn;
  logic [CB_R-1:0] roundCount;
  logic            outValid, keyValid, err;

  int  tests_run = 0;
  int  tests_failed = 0;
  int  cyc = 0;
  int  key_cyc = 0, data_cyc = 0, last_out_cyc = 0;
  int  n_key = 0, n_data = 0, n_round = 0;
  int  exp_rc = 0, rounds = 0;
  logic prev_ov = 1'b0;
  ev_t exp_q[$];

  simon_round_ctrl #(.N(16), .M(4), .T(T_R), .Cb(CB_R)) dut (
    .clk        (clk),
    .R          (R),
    .newKey     (newKey),
    .newData    (newData),
    .outAck     (outAck),
    .loadKey    (loadKey),
    .loadData   (loadData),
    .keyLoad    (keyLoad),
    .blockLoad  (blockLoad),
    .roundEn    (roundEn),
    .roundCount (roundCount),
    .outValid   (outValid),
    .keyValid   (keyValid),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input ev_t got);
    ev_t e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : EV_NONE;
    check("event_order", 64'(e), 64'(got));
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({loadKey, loadData, keyLoad, blockLoad, roundEn, roundCount, outValid, keyValid, err});
  endfunction

  // One clock: sample at the falling edge, score events, model the input stage.
  task automatic tick();
    logic bad;
    @(negedge clk);
    cyc++;
    bad = ($countones({loadKey | keyLoad, loadData | blockLoad, roundEn}) > 1)
        || (loadKey != keyLoad) || (blockLoad && !loadData);
`ifdef SIMON_ROUND_CTRL_ERRCHK_EN
    bad = bad || (err != (loadData && !blockLoad));
`else
    bad = bad || (err !== 1'b0);
`endif
    check("exclusive_outputs", 64'(bad), 64'(0));
    if (loadKey) begin
      n_key++;
      key_cyc = cyc;
      pop_check(EV_KEY);
      check("keyvalid_with_loadkey", 64'(keyValid), 64'(1));
      newKey = 1'b0;
    end
    if (loadData) begin
      n_data++;
      if (blockLoad) begin
        pop_check(EV_DATA);
        data_cyc = cyc;
        exp_rc = 0;
        rounds = 0;
      end else begin
        pop_check(EV_DROP);
        check("drop_err", 64'(err), 64'(1));
      end
      newData = 1'b0;
    end
    if (roundEn) begin
      n_round++;
      check("round_count", 64'(roundCount), 64'(exp_rc));
      exp_rc++;
      rounds++;
    end
    if (outValid && !prev_ov) begin
      pop_check(EV_OUT);
      check("out_latency", 64'(cyc - data_cyc), 64'(T_R + 1));
      check("round_total", 64'(rounds), 64'(T_R));
      last_out_cyc = cyc;
    end
    prev_ov = outValid;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    R = 1'b1;
    newKey = 1'b0;
    newData = 1'b0;
    exp_q.delete();
    tick();
    tick();
    check("reset_outputs", out_vec(), 64'(0));
    R = 1'b0;
  endtask

  initial begin
    int saved_data, saved_key, saved_round, n;

    // Key then block, result acknowledged immediately.
    do_reset();
    outAck = 1'b1;
    exp_q.push_back(EV_KEY);
    newKey = 1'b1;
    wait_drain(10, "t1_key_drain");
    exp_q.push_back(EV_DATA);
    exp_q.push_back(EV_OUT);
    newData = 1'b1;
    wait_drain(60, "t1_block_drain");
    repeat (3) tick();
    check("t1_outvalid_one_cycle", 64'(outValid), 64'(0));
    check("t1_key_count", 64'(n_key), 64'(1));
    check("t1_data_count", 64'(n_data), 64'(1));
    check("t1_round_count", 64'(n_round), 64'(T_R));

    // Block offered before any key.
    do_reset();
    saved_data = n_data;
    saved_round = n_round;
`ifdef SIMON_ROUND_CTRL_ERRCHK_EN
    exp_q.push_back(EV_DROP);
    newData = 1'b1;
    wait_drain(10, "t2_drop_drain");
    tick();
    check("t2_no_rounds", 64'(n_round - saved_round), 64'(0));
    check("t2_no_key", 64'(keyValid), 64'(0));
    newData = 1'b1;
`else
    newData = 1'b1;
    repeat (20) tick();
    check("t2_stall_no_load", 64'(n_data - saved_data), 64'(0));
    check("t2_stall_no_round", 64'(n_round - saved_round), 64'(0));
`endif
    exp_q.push_back(EV_KEY);
    exp_q.push_back(EV_DATA);
    exp_q.push_back(EV_OUT);
    newKey = 1'b1;
    wait_drain(60, "t2_block_drain");
    check("t2_key_to_data", 64'(data_cyc - key_cyc), 64'(2));

    // Simultaneous key and block with a key already held.
    repeat (2) tick();
    exp_q.push_back(EV_KEY);
    exp_q.push_back(EV_DATA);
    exp_q.push_back(EV_OUT);
    newKey = 1'b1;
    newData = 1'b1;
    wait_drain(60, "t3_drain");
    check("t3_key_to_data", 64'(data_cyc - key_cyc), 64'(2));

    // Backpressure: result held, next block waits for the acknowledge.
    repeat (2) tick();
    outAck = 1'b0;
    exp_q.push_back(EV_DATA);
    exp_q.push_back(EV_OUT);
    newData = 1'b1;
    wait_drain(60, "t4_first_drain");
    saved_data = n_data;
    newData = 1'b1;
    repeat (50) tick();
    check("t4_hold_valid", 64'(outValid), 64'(1));
    check("t4_no_load", 64'(n_data - saved_data), 64'(0));
    exp_q.push_back(EV_DATA);
    exp_q.push_back(EV_OUT);
    outAck = 1'b1;
    tick();
    check("t4_ack_drop", 64'(outValid), 64'(0));
    tick();
    check("t4_reload", 64'(loadData), 64'(1));
    wait_drain(60, "t4_second_drain");

    // Key offered mid-block is deferred until the block completes.
    repeat (2) tick();
    exp_q.push_back(EV_DATA);
    exp_q.push_back(EV_OUT);
    exp_q.push_back(EV_KEY);
    saved_key = n_key;
    newData = 1'b1;
    repeat (5) tick();
    newKey = 1'b1;
    repeat (10) tick();
    check("t4b_key_deferred", 64'(n_key - saved_key), 64'(0));
    wait_drain(60, "t4b_drain");
    check("t4b_key_after_out", 64'(key_cyc > last_out_cyc), 64'(1));

    // Reset in the middle of the rounds.
    repeat (2) tick();
    exp_q.push_back(EV_DATA);
    newData = 1'b1;
    n = 0;
    while (!(roundEn && roundCount == CB_R'(10)) && n < 100) begin
      tick();
      n++;
    end
    check("t5_reached_round10", 64'({roundEn, roundCount}), 64'({1'b1, CB_R'(10)}));
    exp_q.delete();
    R = 1'b1;
    #1;
    check("t5_async_clear", out_vec(), 64'(0));
    tick();
    R = 1'b0;
    saved_data = n_data;
    saved_round = n_round;
`ifdef SIMON_ROUND_CTRL_ERRCHK_EN
    exp_q.push_back(EV_DROP);
    newData = 1'b1;
    wait_drain(10, "t5_drop_drain");
`else
    newData = 1'b1;
    repeat (20) tick();
    check("t5_stall_no_load", 64'(n_data - saved_data), 64'(0));
`endif
    check("t5_no_rounds", 64'(n_round - saved_round), 64'(0));
    check("t5_keyvalid_clear", 64'(keyValid), 64'(0));
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
